// File: rtl/dual_issue_fetch_queue_if.sv
// Fetch/decode handshake bundle for the dual-issue fetch queue.
// master = fetch/decode side, slave = queue.
interface dual_issue_fetch_queue_if #(
  parameter int els_p = 8
);
  localparam int lg_els_lp = $clog2(els_p);

  logic              flush_i;
  logic              instr_v_i;
  logic [31:0]       instr_i;
  logic              instr_ready_o;
  logic [31:0]       instruction1_o;
  logic              instruction1_v_o;
  logic [31:0]       instruction2_o;
  logic              instruction2_v_o;
  logic              issue_i;
  logic              dual_issue_i;
  logic [lg_els_lp:0] count_o;

  modport master (
    output flush_i,
    output instr_v_i,
    output instr_i,
    output issue_i,
    output dual_issue_i,
    input  instr_ready_o,
    input  instruction1_o,
    input  instruction1_v_o,
    input  instruction2_o,
    input  instruction2_v_o,
    input  count_o
  );

  modport slave (
    input  flush_i,
    input  instr_v_i,
    input  instr_i,
    input  issue_i,
    input  dual_issue_i,
    output instr_ready_o,
    output instruction1_o,
    output instruction1_v_o,
    output instruction2_o,
    output instruction2_v_o,
    output count_o
  );
endinterface

// File: rtl/dual_issue_fetch_queue.sv
// Circular instruction queue presenting the two oldest entries
// to a dual-issue decoder; retires 0, 1 or 2 entries per cycle.
module dual_issue_fetch_queue #(
  parameter int els_p = 8
) (
  input logic                   clk_i,
  input logic                   reset_i,
  dual_issue_fetch_queue_if.slave fq
);
  localparam int lg_els_lp = $clog2(els_p);
  localparam int cnt_w_lp  = lg_els_lp + 1;
  localparam logic [31:0] nop_lp = 32'h0000_0013;
  localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(els_p);

  logic [31:0]          mem [els_p];
  logic [lg_els_lp-1:0] rptr;
  logic [lg_els_lp-1:0] wptr;
  logic [lg_els_lp-1:0] rptr_p1;
  logic [cnt_w_lp-1:0]  count;
  logic                 v1;
  logic                 v2;
  logic                 ready;
  logic                 enq;
  logic [1:0]           deq_n;

  assign rptr_p1 = rptr + lg_els_lp'(1);
  assign v1      = (count != '0);
  assign v2      = (count > cnt_w_lp'(1));
  assign ready   = ~reset_i & (count < full_lp);
  assign enq     = fq.instr_v_i & ready;

  always_comb begin
    deq_n = 2'd0;
    unique case (1'b1)
      (fq.issue_i & v1 & fq.dual_issue_i & v2):    deq_n = 2'd2;
      (fq.issue_i & v1 & ~(fq.dual_issue_i & v2)): deq_n = 2'd1;
      default:                                     deq_n = 2'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (fq.flush_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= wptr + lg_els_lp'(1);
      rptr  <= rptr + lg_els_lp'(deq_n);
      count <= count + cnt_w_lp'(enq) - cnt_w_lp'(deq_n);
    end
  end

  // Storage is deliberately left unreset; the v flags gate every read.
  always_ff @(posedge clk_i) begin
    if (enq && !fq.flush_i) mem[wptr] <= fq.instr_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && fq.issue_i && fq.dual_issue_i && v1) begin
      assert (v2)
        else $warning("dual issue with a single valid entry");
    end
  end

  assign fq.instr_ready_o    = ready;
  assign fq.instruction1_v_o = v1;
  assign fq.instruction2_v_o = v2;
  assign fq.instruction1_o   = v1 ? mem[rptr] : nop_lp;
  assign fq.instruction2_o   = v2 ? mem[rptr_p1] : nop_lp;
  assign fq.count_o          = count;
endmodule
